// File: rtl/vga_pkg.sv
// ============================================================================
// Module      : vga_pkg
// Description : Default 640x480@60 timing constants and shared types.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package vga_pkg;

  localparam int unsigned DEF_H_VISIBLE = 640;
  localparam int unsigned DEF_H_FRONT   = 16;
  localparam int unsigned DEF_H_SYNC    = 96;
  localparam int unsigned DEF_H_BACK    = 48;
  localparam int unsigned DEF_V_VISIBLE = 480;
  localparam int unsigned DEF_V_FRONT   = 10;
  localparam int unsigned DEF_V_SYNC    = 2;
  localparam int unsigned DEF_V_BACK    = 33;

  localparam int CNT_W = 10;

  typedef logic [3:0] vga_color_t;

  function automatic int unsigned axis_total(input int unsigned vis, input int unsigned front,
                                             input int unsigned sync, input int unsigned back);
    return vis + front + sync + back;
  endfunction

  localparam int unsigned DEF_H_TOTAL = axis_total(DEF_H_VISIBLE, DEF_H_FRONT, DEF_H_SYNC, DEF_H_BACK);
  localparam int unsigned DEF_V_TOTAL = axis_total(DEF_V_VISIBLE, DEF_V_FRONT, DEF_V_SYNC, DEF_V_BACK);

endpackage

`default_nettype wire

// File: rtl/vga_timing_gen_if.sv
// ============================================================================
// Module      : vga_timing_gen_if
// Description : Renderer colour in, raster coordinates and VGA pins out.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface vga_timing_gen_if;
  import vga_pkg::*;

  vga_color_t  red_in;
  vga_color_t  green_in;
  vga_color_t  blue_in;
  logic [9:0]  col;
  logic [8:0]  row;
  logic        display_en;
  logic        hsync;
  logic        vsync;
  logic        frame_end;
  vga_color_t  vga_r;
  vga_color_t  vga_g;
  vga_color_t  vga_b;

  modport master (
    input  red_in, green_in, blue_in,
    output col, row, display_en, hsync, vsync, frame_end, vga_r, vga_g, vga_b
  );

  modport slave (
    output red_in, green_in, blue_in,
    input  col, row, display_en, hsync, vsync, frame_end, vga_r, vga_g, vga_b
  );

endinterface

`default_nettype wire

// File: rtl/vga_axis_counter.sv
// ============================================================================
// Module      : vga_axis_counter
// Description : Modulo-TOTAL raster axis counter advancing when inc is high.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module vga_axis_counter
  import vga_pkg::*;
#(
  parameter int unsigned TOTAL = DEF_H_TOTAL
) (
  input  wire logic             pixel_clk,
  input  wire logic             resetSwitch,
  input  wire logic             inc,
  output logic [CNT_W-1:0]      cnt,
  output logic                  wrap
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // wrap doubles as the increment strobe for the next-slower axis
  assign wrap = inc && (cnt_q == CNT_W'(TOTAL - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (inc) begin
      cnt_d = wrap ? '0 : cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge pixel_clk or negedge resetSwitch) begin
    if (!resetSwitch) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

`default_nettype wire

// File: rtl/vga_timing_gen.sv
// ============================================================================
// Module      : vga_timing_gen
// Description : VGA raster timing, coordinate decode and blank-gated colour.
//               Define VGA_SYNC_DELAY_EN to register syncs and colour gate.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int unsigned H_VISIBLE   = DEF_H_VISIBLE,
  parameter int unsigned H_FRONT     = DEF_H_FRONT,
  parameter int unsigned H_SYNC      = DEF_H_SYNC,
  parameter int unsigned H_BACK      = DEF_H_BACK,
  parameter int unsigned V_VISIBLE   = DEF_V_VISIBLE,
  parameter int unsigned V_FRONT     = DEF_V_FRONT,
  parameter int unsigned V_SYNC      = DEF_V_SYNC,
  parameter int unsigned V_BACK      = DEF_V_BACK,
  parameter logic        SYNC_ACTIVE = 1'b0
) (
  input  wire logic       pixel_clk,
  input  wire logic       resetSwitch,
  vga_timing_gen_if.master vga
);

  localparam int unsigned H_TOTAL = axis_total(H_VISIBLE, H_FRONT, H_SYNC, H_BACK);
  localparam int unsigned V_TOTAL = axis_total(V_VISIBLE, V_FRONT, V_SYNC, V_BACK);
  localparam int unsigned H_SYNC_START = H_VISIBLE + H_FRONT;
  localparam int unsigned H_SYNC_END   = H_SYNC_START + H_SYNC;
  localparam int unsigned V_SYNC_START = V_VISIBLE + V_FRONT;
  localparam int unsigned V_SYNC_END   = V_SYNC_START + V_SYNC;

  if ((H_TOTAL > 1024) || (V_TOTAL > 1024) || (V_VISIBLE > 512)) begin : g_cfg_check
    $error("vga_timing_gen: timing totals exceed counter/coordinate widths");
  end

  logic [CNT_W-1:0] h_cnt;
  logic [CNT_W-1:0] v_cnt;
  logic             h_wrap;
  logic             v_wrap;

  vga_axis_counter #(.TOTAL(H_TOTAL)) u_h_counter (
    .pixel_clk   (pixel_clk),
    .resetSwitch (resetSwitch),
    .inc         (1'b1),
    .cnt         (h_cnt),
    .wrap        (h_wrap)
  );

  vga_axis_counter #(.TOTAL(V_TOTAL)) u_v_counter (
    .pixel_clk   (pixel_clk),
    .resetSwitch (resetSwitch),
    .inc         (h_wrap),
    .cnt         (v_cnt),
    .wrap        (v_wrap)
  );

  logic h_vis;
  logic v_vis;
  logic hsync_d;
  logic vsync_d;
  logic gate_en;

  assign h_vis = h_cnt < CNT_W'(H_VISIBLE);
  assign v_vis = v_cnt < CNT_W'(V_VISIBLE);

  assign vga.display_en = h_vis && v_vis;
  assign vga.col        = h_vis ? h_cnt : '0;
  assign vga.row        = v_vis ? v_cnt[8:0] : '0;
  // v_wrap is only possible while h_wrap is high, so it marks the last pixel
  assign vga.frame_end  = v_wrap;

  assign hsync_d = ((h_cnt >= CNT_W'(H_SYNC_START)) && (h_cnt < CNT_W'(H_SYNC_END)))
                   ? SYNC_ACTIVE : ~SYNC_ACTIVE;
  assign vsync_d = ((v_cnt >= CNT_W'(V_SYNC_START)) && (v_cnt < CNT_W'(V_SYNC_END)))
                   ? SYNC_ACTIVE : ~SYNC_ACTIVE;

`ifdef VGA_SYNC_DELAY_EN
  logic hsync_q;
  logic vsync_q;
  logic gate_q;

  // Aligns pins with renderers that register their colour from col/row
  always_ff @(posedge pixel_clk or negedge resetSwitch) begin
    if (!resetSwitch) begin
      hsync_q <= ~SYNC_ACTIVE;
      vsync_q <= ~SYNC_ACTIVE;
      gate_q  <= 1'b0;
    end else begin
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      gate_q  <= vga.display_en;
    end
  end

  assign vga.hsync = hsync_q;
  assign vga.vsync = vsync_q;
  assign gate_en   = gate_q;
`else
  assign vga.hsync = hsync_d;
  assign vga.vsync = vsync_d;
  assign gate_en   = vga.display_en;
`endif

  assign vga.vga_r = gate_en ? vga.red_in   : 4'h0;
  assign vga.vga_g = gate_en ? vga.green_in : 4'h0;
  assign vga.vga_b = gate_en ? vga.blue_in  : 4'h0;

endmodule

`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
// ============================================================================
// Module      : tb_vga_timing_gen
// Description : Self-checking bench: full-size and shrunken-timing instances.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_vga_timing_gen;
  import vga_pkg::*;

  typedef struct packed {
    int hv, hf, hs, hb, vv, vf, vs, vb;
  } tcfg_t;

  typedef struct packed {
    logic [9:0] col;
    logic [8:0] row;
    logic       de, hs, vs, fe;
    logic [3:0] r, g, b;
  } obs_t;

  typedef struct {
    logic [3:0] r, g, b;
    logic [3:0] er, eg, eb;
    int         cycles;
  } vec_t;

  localparam tcfg_t CFG_B = '{640, 16, 96, 48, 480, 10, 2, 33};
  localparam tcfg_t CFG_S = '{16, 2, 3, 3, 6, 2, 2, 3};
`ifdef VGA_SYNC_DELAY_EN
  localparam int D = 1;
`else
  localparam int D = 0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  vga_timing_gen_if vif_b ();
  vga_timing_gen_if vif_s ();

  vga_timing_gen u_big (
    .pixel_clk   (clk),
    .resetSwitch (rst_n),
    .vga         (vif_b)
  );

  vga_timing_gen #(
    .H_VISIBLE (16), .H_FRONT (2), .H_SYNC (3), .H_BACK (3),
    .V_VISIBLE (6),  .V_FRONT (2), .V_SYNC (2), .V_BACK (3),
    .SYNC_ACTIVE (1'b0)
  ) u_small (
    .pixel_clk   (clk),
    .resetSwitch (rst_n),
    .vga         (vif_s)
  );

  int   n_checks = 0;
  int   n_fail   = 0;
  int   n        = 0;
  bit   pv       = 1'b0;
  int   s_n      = 0;
  obs_t sb, ss;
  obs_t qb[$];
  obs_t qs[$];
  vec_t vecs[8];

  function automatic obs_t decode(input tcfg_t c, input int k);
    obs_t o;
    int ht, vt, h, v;
    ht = c.hv + c.hf + c.hs + c.hb;
    vt = c.vv + c.vf + c.vs + c.vb;
    h  = k % ht;
    v  = (k / ht) % vt;
    o     = '0;
    o.de  = (h < c.hv) && (v < c.vv);
    o.col = (h < c.hv) ? 10'(h) : 10'd0;
    o.row = (v < c.vv) ? 9'(v) : 9'd0;
    o.hs  = (h >= c.hv + c.hf && h < c.hv + c.hf + c.hs) ? 1'b0 : 1'b1;
    o.vs  = (v >= c.vv + c.vf && v < c.vv + c.vf + c.vs) ? 1'b0 : 1'b1;
    o.fe  = (h == ht - 1) && (v == vt - 1);
    return o;
  endfunction

  function automatic obs_t model(input tcfg_t c, input int k, input bit prev_ok,
                                 input logic [3:0] er, input logic [3:0] eg, input logic [3:0] eb);
    obs_t o, p;
    logic gate;
    o    = decode(c, k);
    gate = o.de;
    if (D == 1) begin
      if (prev_ok) begin
        p    = decode(c, k - 1);
        o.hs = p.hs;
        o.vs = p.vs;
        gate = p.de;
      end else begin
        o.hs = 1'b1;
        o.vs = 1'b1;
        gate = 1'b0;
      end
    end
    o.r = gate ? er : 4'h0;
    o.g = gate ? eg : 4'h0;
    o.b = gate ? eb : 4'h0;
    return o;
  endfunction

  task automatic check_obs(input string nm, input obs_t got, input obs_t exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s n=%0d got col=%0d row=%0d de=%b hs=%b vs=%b fe=%b rgb=%h%h%h expected col=%0d row=%0d de=%b hs=%b vs=%b fe=%b rgb=%h%h%h",
               nm, s_n, got.col, got.row, got.de, got.hs, got.vs, got.fe, got.r, got.g, got.b,
               exp.col, exp.row, exp.de, exp.hs, exp.vs, exp.fe, exp.r, exp.g, exp.b);
    end
  endtask

  task automatic check_int(input string nm, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s got=%0d expected=%0d", nm, got, exp);
    end
  endtask

  task automatic set_rgb(input logic [3:0] r, input logic [3:0] g, input logic [3:0] b);
    vif_b.red_in = r; vif_b.green_in = g; vif_b.blue_in = b;
    vif_s.red_in = r; vif_s.green_in = g; vif_s.blue_in = b;
  endtask

  // One pixel: queue expectations, sample mid-cycle, compare, advance to next edge
  task automatic step(input logic [3:0] er, input logic [3:0] eg, input logic [3:0] eb);
    qb.push_back(model(CFG_B, n, pv, er, eg, eb));
    qs.push_back(model(CFG_S, n, pv, er, eg, eb));
    #2;
    s_n = n;
    sb = {vif_b.col, vif_b.row, vif_b.display_en, vif_b.hsync, vif_b.vsync,
          vif_b.frame_end, vif_b.vga_r, vif_b.vga_g, vif_b.vga_b};
    ss = {vif_s.col, vif_s.row, vif_s.display_en, vif_s.hsync, vif_s.vsync,
          vif_s.frame_end, vif_s.vga_r, vif_s.vga_g, vif_s.vga_b};
    check_obs("big", sb, qb.pop_front());
    check_obs("small", ss, qs.pop_front());
    @(posedge clk);
    #1;
    if (rst_n) begin
      n++;
      pv = 1'b1;
    end else begin
      n  = 0;
      pv = 1'b0;
    end
  endtask

  initial begin
    obs_t prev_b, prev_s;
    int hs_fall, hs_low, de_rise, gate_rise, vs_fall, vs_low;
    int fe_n[$];

    vecs[0] = '{4'hF, 4'h0, 4'hF, 4'hF, 4'h0, 4'hF, 250};
    vecs[1] = '{4'h1, 4'h2, 4'h3, 4'h1, 4'h2, 4'h3, 250};
    vecs[2] = '{4'hA, 4'h5, 4'hC, 4'hA, 4'h5, 4'hC, 250};
    vecs[3] = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 250};
    vecs[4] = '{4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 250};
    vecs[5] = '{4'h8, 4'h4, 4'h2, 4'h8, 4'h4, 4'h2, 250};
    vecs[6] = '{4'h7, 4'hE, 4'h9, 4'h7, 4'hE, 4'h9, 250};
    vecs[7] = '{4'h3, 4'hB, 4'h6, 4'h3, 4'hB, 4'h6, 250};

    // Power-up reset
    set_rgb(4'hF, 4'h0, 4'hF);
    rst_n = 1'b0;
    n = 0;
    pv = 1'b0;
    #1;
    step(4'hF, 4'h0, 4'hF);
    step(4'hF, 4'h0, 4'hF);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      set_rgb(vecs[i].r, vecs[i].g, vecs[i].b);
      for (int c = 0; c < vecs[i].cycles; c++) begin
        step(vecs[i].er, vecs[i].eg, vecs[i].eb);
      end
    end

    // Park the small raster mid-frame (h=10, v=3), then reset asynchronously
    set_rgb(4'hF, 4'h0, 4'hF);
    for (int c = 0; c < 400 && (n % 312) != 82; c++) begin
      step(4'hF, 4'h0, 4'hF);
    end
    check_int("park_position", n % 312, 82);
    rst_n = 1'b0;
    n = 0;
    pv = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step(4'hF, 4'h0, 4'hF);
    end
    rst_n = 1'b1;

    // Fresh run from (0,0): measure edges against the raster schedule
    hs_fall = -1; de_rise = -1; gate_rise = -1; vs_fall = -1;
    hs_low = 0; vs_low = 0;
    prev_b = '0; prev_s = '0;
    for (int k = 0; k < 810; k++) begin
      step(4'hF, 4'h0, 4'hF);
      if (s_n > 0) begin
        if (prev_b.hs && !sb.hs && hs_fall < 0) hs_fall = s_n;
        if (!prev_b.de && sb.de && de_rise < 0) de_rise = s_n;
        if (prev_b.r == 4'h0 && sb.r != 4'h0 && s_n >= 700 && gate_rise < 0) gate_rise = s_n;
        if (prev_s.vs && !ss.vs && vs_fall < 0) vs_fall = s_n;
      end
      if (s_n < 800 && !sb.hs) hs_low++;
      if (s_n < 312 && !ss.vs) vs_low++;
      if (ss.fe) fe_n.push_back(s_n);
      prev_b = sb;
      prev_s = ss;
    end

    check_int("hsync_fall_cycle", hs_fall, 656 + D);
    check_int("hsync_low_width", hs_low, 96);
    check_int("display_en_rise_line1", de_rise, 800);
    check_int("colour_gate_open_line1", gate_rise, 800 + D);
    check_int("vsync_fall_cycle_small", vs_fall, 192 + D);
    check_int("vsync_low_width_small", vs_low, 48);
    check_int("frame_end_count_small", fe_n.size(), 2);
    if (fe_n.size() >= 2) begin
      check_int("frame_end_first_small", fe_n[0], 311);
      check_int("frame_end_period_small", fe_n[1] - fe_n[0], 312);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/vga_timing_gen.md
# vga_timing_gen

Generates 640x480@60 VGA raster timing from `pixel_clk` and drives the pixel coordinates (`col`, `row`) that the level renderers use to choose colours. It also returns the renderer's RGB to the monitor, forced to black during blanking. A once-per-frame `frame_end` pulse is available as a movement tick for game logic. It sits directly upstream of each level module and directly drives the VGA connector pins.

## Interface
- H_VISIBLE, 640, active pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width (pixels)
- H_BACK, 48, horizontal back porch (pixels)
- V_VISIBLE, 480, active lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BACK, 33, vertical back porch (lines)
- SYNC_ACTIVE, 0, asserted level of both hsync and vsync
- pixel_clk  in  1  pixel clock (25.175 MHz nominal); the only clock
- resetSwitch  in  1  asynchronous, active-low reset
- red_in / green_in / blue_in  in  4 each  colour from the downstream renderer
- col  out  10  current visible column, 0..H_VISIBLE-1
- row  out  9  current visible line, 0..V_VISIBLE-1
- display_en  out  1  high while (col,row) is visible
- hsync  out  1  horizontal sync
- vsync  out  1  vertical sync
- frame_end  out  1  one-cycle pulse on the last pixel of each frame
- vga_r / vga_g / vga_b  out  4 each  monitor colour

## Operation
- Derived values: H_TOTAL = sum of the H_* parameters (800); V_TOTAL = sum of the V_* parameters (525).
- Width constraints: H_TOTAL ≤ 1024, V_TOTAL ≤ 1024, V_VISIBLE ≤ 512. An elaboration-time assertion enforces them.
- Horizontal counter `h_cnt` (10 bit):
  - Increments every cycle.
  - Wraps from H_TOTAL-1 to 0.
- Vertical counter `v_cnt` (10 bit):
  - Increments only on the cycle `h_cnt` wraps.
  - Wraps from V_TOTAL-1 to 0 on that same cycle.
- display_en = (h_cnt < H_VISIBLE) && (v_cnt < V_VISIBLE).
- col = h_cnt when h_cnt < H_VISIBLE, else 0.
- row = v_cnt[8:0] when v_cnt < V_VISIBLE, else 0. Out-of-range values never alias into the visible range.
- hsync = SYNC_ACTIVE when h_cnt is in [H_VISIBLE+H_FRONT, H_VISIBLE+H_FRONT+H_SYNC), i.e. [656,752); otherwise its inverse.
- vsync = SYNC_ACTIVE when v_cnt is in [490,492), for whole lines; otherwise its inverse.
- frame_end = (h_cnt == H_TOTAL-1) && (v_cnt == V_TOTAL-1).
- vga_{r,g,b} = {r,g,b}_in when the gating enable is high, else 4'h0.
  - The gating enable is display_en, or its delayed copy under the Configuration macro.

## Timing
- col, row, display_en, hsync, vsync and frame_end are combinational decodes of the counter registers. They have zero latency relative to the counter state.
- Reset asserted, asynchronously:
  - h_cnt and v_cnt go to 0 immediately.
  - col=0, row=0, display_en=1, hsync/vsync inactive (~SYNC_ACTIVE), frame_end=0.
- Reset mid-frame: the counters return to 0 without finishing the line or frame. No frame_end pulse is emitted for the aborted frame.
- After reset deasserts, the first active clock edge advances h_cnt to 1.
  - The first frame_end is high during the 420000th cycle, counting from cycle 1 at (0,0).
  - Thereafter frame_end fires exactly every H_TOTAL*V_TOTAL = 420000 cycles.
- Line boundary: the 799→0 transition of h_cnt and the increment of v_cnt happen on the same edge.
- Frame boundary: h_cnt 799→0 and v_cnt 524→0 happen on the same edge.
- RGB gating is purely combinational from the registered enable; there is no added colour latency.

## Configuration
- Macro: VGA_SYNC_DELAY_EN.
- Defined:
  - hsync, vsync and the RGB-gating enable pass through one `pixel_clk` register stage.
  - Reset values of that stage: enable 0, syncs inactive.
  - Purpose: matches renderers whose colour output is registered from col/row, giving a one-cycle colour latency.
  - col, row, display_en and frame_end are not delayed.
- Undefined:
  - No delay stage.
  - hsync/vsync/gating follow the counter decode directly, for renderers that produce combinational colour.

## Structure
- Package `vga_pkg`:
  - Default timing constants (640/16/96/48, 480/10/2/33).
  - H_TOTAL/V_TOTAL computation.
  - Counter width localparam (10).
  - A `vga_color_t` typedef for the 4-bit channels.
- Sub-module `vga_axis_counter` (parameter TOTAL; ports pixel_clk, resetSwitch, inc, cnt, wrap):
  - Instantiated once for horizontal (inc = 1) and once for vertical (inc = horizontal wrap).
- The top level holds the decode, the optional delay stage and the RGB gating.

## Test plan
- Reset, then release: col counts 0,1,...,639, then holds 0 with display_en=0 for 160 cycles; row increments to 1 at cycle 800.
- hsync: low (SYNC_ACTIVE=0) for exactly 96 cycles, starting 656 cycles after each line start; vsync low for exactly 2 lines (1600 cycles), starting at line 490.
- frame_end: exactly one pulse per 420000 cycles, coincident with h_cnt=799/v_cnt=524; the next cycle shows col=0, row=0, display_en=1.
- RGB gating: drive red_in=4'hF, green_in=4'h0, blue_in=4'hF constantly; vga outputs must be F/0/F only while display_en is high (or its delayed copy), else 0/0/0.
- Mid-line reset: assert resetSwitch at h_cnt=300, v_cnt=100 for 3 cycles; counters read 0 during reset, no frame_end pulse, and counting restarts from 0 at release.
- With VGA_SYNC_DELAY_EN: hsync falls at cycle 657 instead of 656 after line start, and colour gating opens 1 cycle after display_en rises; without the macro the offset is 0.
